// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: turns the EXE result into a data-memory access (or
// passes it through), formats sub-word load/store data by byte lane, stalls
// the front of the pipe while an access is outstanding, and registers the
// write-back value toward MEM/WB.
//
// Memory handshake: DMemReq_OUT is held high from the cycle after an access
// is accepted until the first cycle DMemReady_IN is sampled high; request
// fields stay constant for that whole window and are forced to zero whenever
// DMemReq_OUT is low. DMemReady_IN is ignored while no request is pending.
module mem_access_stage (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] ALUResult_IN,
    input  logic [31:0] StoreData_IN,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic [1:0]  MemSize_IN,
    input  logic        MemSigned_IN,
    input  logic        RegWrite_IN,
    input  logic [4:0]  WriteRegister_IN,
    input  logic        Valid_IN,
    input  logic        Flush_IN,
    output logic        DMemReq_OUT,
    output logic        DMemWrite_OUT,
    output logic [31:0] DMemAddr_OUT,
    output logic [31:0] DMemWriteData_OUT,
    output logic [3:0]  DMemByteEn_OUT,
    input  logic        DMemReady_IN,
    input  logic [31:0] DMemReadData_IN,
    output logic [31:0] Result_OUT,
    output logic [4:0]  WriteRegister_OUT,
    output logic        RegWrite_OUT,
    output logic        Valid_OUT,
    output logic        AddrError_OUT,
    output logic        Stall_OUT
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // FSM encoding; "state" is the signal to probe for the current phase.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]  state;
    logic        busy;

    // Access captured at acceptance; drives the memory port during BUSY.
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic        lat_load;
    logic        lat_store;
    logic        lat_regwrite;
    logic [4:0]  lat_dest;

    // Decode of the instruction currently presented.
    logic        mem_op;
    logic        size_mis;
    logic        misaligned;
    logic        access;

    // Formatted memory-side data.
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign busy = (state == ST_BUSY);

    // Classify the presented instruction: memory op, alignment, real access.
    always_comb begin
        mem_op   = MemRead_IN | MemWrite_IN;
        size_mis = 1'b0;
        unique case (MemSize_IN)
            SIZE_BYTE: size_mis = 1'b0;
            SIZE_HALF: size_mis = ALUResult_IN[0];
            default:   size_mis = |ALUResult_IN[1:0];
        endcase
        misaligned = mem_op & size_mis;
        access     = Valid_IN & mem_op & ~misaligned & ~Flush_IN;
    end

    // Replicate store data across lanes and build byte enables from the latched access.
    always_comb begin
        st_data = lat_data;
        st_be   = 4'b1111;
        unique case (lat_size)
            SIZE_BYTE: begin
                st_data = {4{lat_data[7:0]}};
                st_be   = 4'b0001 << lat_addr[1:0];
            end
            SIZE_HALF: begin
                st_data = {2{lat_data[15:0]}};
                st_be   = 4'b0011 << lat_addr[1:0];
            end
            default: begin
                st_data = lat_data;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Pick the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        ld_byte = DMemReadData_IN[7:0];
        unique case (lat_addr[1:0])
            2'd0: ld_byte = DMemReadData_IN[7:0];
            2'd1: ld_byte = DMemReadData_IN[15:8];
            2'd2: ld_byte = DMemReadData_IN[23:16];
            default: ld_byte = DMemReadData_IN[31:24];
        endcase
        ld_half = lat_addr[1] ? DMemReadData_IN[31:16] : DMemReadData_IN[15:0];
        ld_data = DMemReadData_IN;
        unique case (lat_size)
            SIZE_BYTE: ld_data = {{24{lat_signed & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data = {{16{lat_signed & ld_half[15]}}, ld_half};
            default:   ld_data = DMemReadData_IN;
        endcase
    end

    // Memory port and stall; everything is zeroed outside BUSY so reset drops the request at once.
    always_comb begin
        DMemReq_OUT       = busy;
        DMemWrite_OUT     = busy & lat_store;
        DMemAddr_OUT      = busy ? {lat_addr[31:2], 2'b00} : 32'd0;
        DMemWriteData_OUT = (busy & lat_store) ? st_data : 32'd0;
        DMemByteEn_OUT    = busy ? st_be : 4'd0;
        Stall_OUT         = busy ? ~DMemReady_IN : access;
    end

    // IDLE/BUSY sequencing and capture of the accepted access.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            lat_addr     <= 32'd0;
            lat_data     <= 32'd0;
            lat_size     <= 2'd0;
            lat_signed   <= 1'b0;
            lat_load     <= 1'b0;
            lat_store    <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_dest     <= 5'd0;
        end else if (state == ST_IDLE) begin
            if (access) begin
                state        <= ST_BUSY;
                lat_addr     <= ALUResult_IN;
                lat_data     <= StoreData_IN;
                lat_size     <= MemSize_IN;
                lat_signed   <= MemSigned_IN;
                lat_load     <= MemRead_IN;
                lat_store    <= MemWrite_IN;
                lat_regwrite <= RegWrite_IN;
                lat_dest     <= WriteRegister_IN;
            end
        end else begin
            // Flush is deliberately not looked at here: an issued access always commits.
            if (DMemReady_IN) begin
                state <= ST_IDLE;
            end
        end
    end

    // MEM/WB output registers: pass-through, bubble on acceptance, commit on ready.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            Result_OUT        <= 32'd0;
            WriteRegister_OUT <= 5'd0;
            RegWrite_OUT      <= 1'b0;
            Valid_OUT         <= 1'b0;
            AddrError_OUT     <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (access) begin
                Result_OUT        <= 32'd0;
                WriteRegister_OUT <= 5'd0;
                RegWrite_OUT      <= 1'b0;
                Valid_OUT         <= 1'b0;
                AddrError_OUT     <= 1'b0;
            end else begin
                Result_OUT        <= ALUResult_IN;
                WriteRegister_OUT <= WriteRegister_IN;
                RegWrite_OUT      <= RegWrite_IN & Valid_IN & ~Flush_IN & ~misaligned;
                Valid_OUT         <= Valid_IN & ~Flush_IN;
                AddrError_OUT     <= Valid_IN & ~Flush_IN & misaligned;
            end
        end else if (DMemReady_IN) begin
            Result_OUT        <= lat_load ? ld_data : 32'd0;
            WriteRegister_OUT <= lat_dest;
            RegWrite_OUT      <= lat_regwrite & lat_load;
            Valid_OUT         <= 1'b1;
            AddrError_OUT     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level reference model
// predicts every output each cycle, and the directed sequences pin the
// model with hand-computed literals.
module tb_mem_access_stage;

    logic        CLOCK;
    logic        RESET;
    logic [31:0] ALUResult_IN;
    logic [31:0] StoreData_IN;
    logic        MemRead_IN;
    logic        MemWrite_IN;
    logic [1:0]  MemSize_IN;
    logic        MemSigned_IN;
    logic        RegWrite_IN;
    logic [4:0]  WriteRegister_IN;
    logic        Valid_IN;
    logic        Flush_IN;
    logic        DMemReq_OUT;
    logic        DMemWrite_OUT;
    logic [31:0] DMemAddr_OUT;
    logic [31:0] DMemWriteData_OUT;
    logic [3:0]  DMemByteEn_OUT;
    logic        DMemReady_IN;
    logic [31:0] DMemReadData_IN;
    logic [31:0] Result_OUT;
    logic [4:0]  WriteRegister_OUT;
    logic        RegWrite_OUT;
    logic        Valid_OUT;
    logic        AddrError_OUT;
    logic        Stall_OUT;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    mem_access_stage dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .ALUResult_IN(ALUResult_IN), .StoreData_IN(StoreData_IN),
        .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
        .MemSize_IN(MemSize_IN), .MemSigned_IN(MemSigned_IN),
        .RegWrite_IN(RegWrite_IN), .WriteRegister_IN(WriteRegister_IN),
        .Valid_IN(Valid_IN), .Flush_IN(Flush_IN),
        .DMemReq_OUT(DMemReq_OUT), .DMemWrite_OUT(DMemWrite_OUT),
        .DMemAddr_OUT(DMemAddr_OUT), .DMemWriteData_OUT(DMemWriteData_OUT),
        .DMemByteEn_OUT(DMemByteEn_OUT), .DMemReady_IN(DMemReady_IN),
        .DMemReadData_IN(DMemReadData_IN), .Result_OUT(Result_OUT),
        .WriteRegister_OUT(WriteRegister_OUT), .RegWrite_OUT(RegWrite_OUT),
        .Valid_OUT(Valid_OUT), .AddrError_OUT(AddrError_OUT),
        .Stall_OUT(Stall_OUT)
    );

    // Clock
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_misaligned(input bit mem, input logic [1:0] size, input logic [31:0] addr);
        return mem && ((addr % nbytes(size)) != 0);
    endfunction

    function automatic bit is_access(input bit valid, input bit rd, input bit wr,
                                     input logic [1:0] size, input logic [31:0] addr, input bit flush);
        return valid && (rd || wr) && !is_misaligned(rd || wr, size, addr) && !flush;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
        int nb = nbytes(size);
        int lane = (nb == 4) ? 0 : int'(addr[1:0]);
        return 4'(((1 << nb) - 1) << lane);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] d);
        int nb = nbytes(size);
        if (nb == 1) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (nb == 2) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] addr,
                                             input logic [1:0] size, input bit sgn);
        int nb = nbytes(size);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rd >> (8 * int'(addr[1:0]))) & mask;
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    bit          m_busy;
    logic [31:0] m_addr, m_sdata;
    logic [1:0]  m_size;
    bit          m_signed, m_load, m_store, m_rw;
    logic [4:0]  m_dest;
    logic [31:0] e_result;
    logic [4:0]  e_dest;
    bit          e_regwrite, e_valid, e_adderr, e_chk;

    // Model: advance one instruction-level step per clock edge.
    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            m_busy = 0; e_result = 0; e_dest = 0;
            e_regwrite = 0; e_valid = 0; e_adderr = 0; e_chk = 1;
        end else if (!m_busy) begin
            bit mem, mis;
            mem = MemRead_IN || MemWrite_IN;
            mis = is_misaligned(mem, MemSize_IN, ALUResult_IN);
            if (is_access(Valid_IN, MemRead_IN, MemWrite_IN, MemSize_IN, ALUResult_IN, Flush_IN)) begin
                m_busy = 1; m_addr = ALUResult_IN; m_sdata = StoreData_IN; m_size = MemSize_IN;
                m_signed = MemSigned_IN; m_load = MemRead_IN; m_store = MemWrite_IN;
                m_rw = RegWrite_IN; m_dest = WriteRegister_IN;
                e_valid = 0; e_regwrite = 0; e_chk = 0;
            end else begin
                e_result   = ALUResult_IN;
                e_dest     = WriteRegister_IN;
                e_regwrite = RegWrite_IN && Valid_IN && !Flush_IN && !mis;
                e_valid    = Valid_IN && !Flush_IN;
                e_adderr   = Valid_IN && !Flush_IN && mis && mem;
                e_chk      = 1;
            end
        end else if (DMemReady_IN) begin
            e_result   = m_load ? exp_load(DMemReadData_IN, m_addr, m_size, m_signed) : 32'd0;
            e_dest     = m_dest;
            e_regwrite = m_rw && m_load;
            e_valid    = 1;
            e_adderr   = 0;
            e_chk      = 1;
            m_busy     = 0;
        end
    end

    // Compare process: every output checked against the model at mid-cycle.
    always @(negedge CLOCK) begin
        if (cmp_en) begin
            bit e_stall;
            e_stall = m_busy ? !DMemReady_IN
                             : is_access(Valid_IN, MemRead_IN, MemWrite_IN, MemSize_IN, ALUResult_IN, Flush_IN);
            check("stall", 32'(Stall_OUT), 32'(e_stall));
            check("dmem_req", 32'(DMemReq_OUT), 32'(m_busy));
            check("dmem_addr", DMemAddr_OUT, m_busy ? (m_addr & 32'hFFFF_FFFC) : 32'd0);
            check("dmem_write", 32'(DMemWrite_OUT), 32'(m_busy && m_store));
            if (!m_busy) begin
                check("dmem_be_idle", 32'(DMemByteEn_OUT), 32'd0);
                check("dmem_wdata_idle", DMemWriteData_OUT, 32'd0);
            end else if (m_store) begin
                check("dmem_be", 32'(DMemByteEn_OUT), 32'(exp_be(m_size, m_addr)));
                check("dmem_wdata", DMemWriteData_OUT, exp_wdata(m_size, m_sdata));
            end
            check("valid_out", 32'(Valid_OUT), 32'(e_valid));
            check("regwrite_out", 32'(RegWrite_OUT), 32'(e_regwrite));
            if (e_chk) begin
                check("result_out", Result_OUT, e_result);
                check("dest_out", 32'(WriteRegister_OUT), 32'(e_dest));
                check("adderr_out", 32'(AddrError_OUT), 32'(e_adderr));
            end
        end
    end

    // ---------------- driver ----------------
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_write;

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic idle_inputs();
        Valid_IN = 0; MemRead_IN = 0; MemWrite_IN = 0; MemSize_IN = 2'b10;
        MemSigned_IN = 0; RegWrite_IN = 0; WriteRegister_IN = 0;
        ALUResult_IN = 0; StoreData_IN = 0; Flush_IN = 0;
    endtask

    task automatic present(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                           input bit rw, input logic [4:0] dest, input logic [31:0] alu,
                           input logic [31:0] sdata, input bit flush);
        Valid_IN = 1; MemRead_IN = rd; MemWrite_IN = wr; MemSize_IN = size;
        MemSigned_IN = sgn; RegWrite_IN = rw; WriteRegister_IN = dest;
        ALUResult_IN = alu; StoreData_IN = sdata; Flush_IN = flush;
    endtask

    // Access already presented this cycle: wait n_wait cycles, then complete.
    task automatic run_mem(input int n_wait, input logic [31:0] rdata, input bit flush_busy,
                           output int stalls);
        stalls = 0;
        @(negedge CLOCK);
        if (Stall_OUT) stalls++;
        for (int i = 0; i < n_wait; i++) begin
            tick();
            if (flush_busy) Flush_IN = 1;
            @(negedge CLOCK);
            if (Stall_OUT) stalls++;
        end
        tick();
        if (flush_busy) Flush_IN = 1;
        DMemReady_IN = 1;
        DMemReadData_IN = rdata;
        @(negedge CLOCK);
        if (Stall_OUT) stalls++;
        cap_addr = DMemAddr_OUT; cap_be = DMemByteEn_OUT;
        cap_wdata = DMemWriteData_OUT; cap_write = DMemWrite_OUT;
    endtask

    task automatic finish_mem();
        tick();
        DMemReady_IN = 0;
        DMemReadData_IN = 32'h0;
        idle_inputs();
        #1;
    endtask

    initial begin
        int st;
        RESET = 0;
        DMemReady_IN = 0;
        DMemReadData_IN = 0;
        idle_inputs();
        #1;
        check("reset_valid", 32'(Valid_OUT), 32'd0);
        check("reset_result", Result_OUT, 32'd0);
        check("reset_req", 32'(DMemReq_OUT), 32'd0);
        cmp_en = 1;
        repeat (2) @(posedge CLOCK);
        #2 RESET = 1;

        // Pass-through
        tick();
        present(0, 0, 2'b10, 0, 1, 5'd9, 32'h1234_5678, 32'h0, 0);
        @(negedge CLOCK);
        st = Stall_OUT;
        tick();
        idle_inputs();
        #1;
        check("pt_result", Result_OUT, 32'h1234_5678);
        check("pt_dest", 32'(WriteRegister_OUT), 32'd9);
        check("pt_regwrite", 32'(RegWrite_OUT), 32'd1);
        check("pt_stall", 32'(st), 32'd0);

        // Signed byte load, lane 3, two wait cycles
        tick();
        present(1, 0, 2'b00, 1, 1, 5'd3, 32'h0000_0103, 32'h0, 0);
        run_mem(2, 32'h80FF_FF7F, 0, st);
        check("sb_addr", cap_addr, 32'h0000_0100);
        check("sb_stall_cycles", 32'(st), 32'd3);
        finish_mem();
        check("sb_result", Result_OUT, 32'hFFFF_FF80);
        check("sb_regwrite", 32'(RegWrite_OUT), 32'd1);

        // Unsigned variant
        tick();
        present(1, 0, 2'b00, 0, 1, 5'd4, 32'h0000_0103, 32'h0, 0);
        run_mem(2, 32'h80FF_FF7F, 0, st);
        finish_mem();
        check("ub_result", Result_OUT, 32'h0000_0080);

        // Half store, upper lane, ready immediately
        tick();
        present(0, 1, 2'b01, 0, 1, 5'd7, 32'h0000_0202, 32'hAAAA_BEEF, 0);
        run_mem(0, 32'h0, 0, st);
        check("hs_write", 32'(cap_write), 32'd1);
        check("hs_be", 32'(cap_be), 32'hC);
        check("hs_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("hs_stall_cycles", 32'(st), 32'd1);
        finish_mem();
        check("hs_regwrite", 32'(RegWrite_OUT), 32'd0);
        check("hs_valid", 32'(Valid_OUT), 32'd1);

        // Byte store lane 1
        tick();
        present(0, 1, 2'b00, 0, 0, 5'd0, 32'h0000_0101, 32'h1234_565A, 0);
        run_mem(1, 32'h0, 0, st);
        check("bs_be", 32'(cap_be), 32'h2);
        check("bs_wdata", cap_wdata, 32'h5A5A_5A5A);
        finish_mem();

        // Misaligned word load
        tick();
        present(1, 0, 2'b10, 0, 1, 5'd5, 32'h0000_0101, 32'h0, 0);
        @(negedge CLOCK);
        st = DMemReq_OUT;
        tick();
        idle_inputs();
        #1;
        check("mis_req", 32'(st), 32'd0);
        check("mis_adderr", 32'(AddrError_OUT), 32'd1);
        check("mis_regwrite", 32'(RegWrite_OUT), 32'd0);

        // Flush with a load presented in IDLE
        tick();
        present(1, 0, 2'b10, 0, 1, 5'd6, 32'h0000_0200, 32'h0, 1);
        tick();
        idle_inputs();
        #1;
        check("fl_idle_valid", 32'(Valid_OUT), 32'd0);

        // Flush during BUSY: signed half load lane 2 still commits
        tick();
        present(1, 0, 2'b01, 1, 1, 5'd10, 32'h0000_0102, 32'h0, 0);
        run_mem(1, 32'h8001_1234, 1, st);
        finish_mem();
        check("fl_busy_valid", 32'(Valid_OUT), 32'd1);
        check("fl_busy_result", Result_OUT, 32'hFFFF_8001);

        // Back-to-back loads: one request-free cycle in between
        tick();
        present(1, 0, 2'b10, 0, 1, 5'd11, 32'h0000_0300, 32'h0, 0);
        run_mem(1, 32'h1111_2222, 0, st);
        tick();
        DMemReady_IN = 0;
        present(1, 0, 2'b00, 0, 1, 5'd12, 32'h0000_0302, 32'h0, 0);
        #1;
        check("b2b_first_result", Result_OUT, 32'h1111_2222);
        check("b2b_gap_req", 32'(DMemReq_OUT), 32'd0);
        run_mem(0, 32'h00AB_0000, 0, st);
        finish_mem();
        check("b2b_second_result", Result_OUT, 32'h0000_00AB);

        // Reset while BUSY
        tick();
        present(1, 0, 2'b10, 0, 1, 5'd13, 32'h0000_0400, 32'h0, 0);
        tick();
        tick();
        #1;
        check("rb_req_before", 32'(DMemReq_OUT), 32'd1);
        @(posedge CLOCK);
        #2;
        RESET = 0;
        idle_inputs();
        #1;
        check("rb_req", 32'(DMemReq_OUT), 32'd0);
        check("rb_addr", DMemAddr_OUT, 32'd0);
        check("rb_stall", 32'(Stall_OUT), 32'd0);
        check("rb_valid", 32'(Valid_OUT), 32'd0);
        check("rb_result", Result_OUT, 32'd0);
        @(posedge CLOCK);
        #2 RESET = 1;

        // Normal load after reset
        tick();
        present(1, 0, 2'b10, 0, 1, 5'd14, 32'h0000_0500, 32'h0, 0);
        run_mem(1, 32'hDEAD_BEEF, 0, st);
        check("ar_addr", cap_addr, 32'h0000_0500);
        finish_mem();
        check("ar_result", Result_OUT, 32'hDEAD_BEEF);
        check("ar_dest", 32'(WriteRegister_OUT), 32'd14);

        repeat (2) @(posedge CLOCK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

- Pipeline MEM stage. Sits directly downstream of the EXE stage and the EX/MEM register.
- Takes the ALU result as either a data address or a pass-through value, and runs loads/stores against a data memory with variable latency over a req/ready handshake.
- Formats sub-word data with byte-lane steering and sign/zero extension, and raises a stall while an access is in flight.
- Registers the write-back value, destination and valid toward MEM/WB.

## Interface
Parameters: none.

Ports:
- CLOCK  in  1  single clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ALUResult_IN  in  32  EXE result; byte address when MemRead_IN/MemWrite_IN.
- StoreData_IN  in  32  store source register value (already forwarded).
- MemRead_IN  in  1  load.
- MemWrite_IN  in  1  store. Never set together with MemRead_IN.
- MemSize_IN  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MemSigned_IN  in  1  sign-extend sub-word loads.
- RegWrite_IN  in  1  instruction writes a register.
- WriteRegister_IN  in  5  destination register.
- Valid_IN  in  1  an instruction is present.
- Flush_IN  in  1  kill the instruction presented this cycle.
- DMemReq_OUT  out  1  memory request.
- DMemWrite_OUT  out  1  request is a write.
- DMemAddr_OUT  out  32  word address (bits 1:0 forced 0).
- DMemWriteData_OUT  out  32  lane-replicated store data.
- DMemByteEn_OUT  out  4  byte enables; bit n = bits 8n+7:8n.
- DMemReady_IN  in  1  memory completes the request this cycle.
- DMemReadData_IN  in  32  read word, valid when DMemReady_IN=1.
- Result_OUT  out  32  registered write-back value.
- WriteRegister_OUT  out  5  registered destination.
- RegWrite_OUT  out  1  registered write enable.
- Valid_OUT  out  1  registered instruction valid.
- AddrError_OUT  out  1  registered misaligned-access flag.
- Stall_OUT  out  1  combinational. Upstream holds all inputs stable while it is 1.

## Operation
Access definition:
- access = Valid_IN & (MemRead_IN | MemWrite_IN) & aligned & !Flush_IN.
- Misaligned cases: half with addr[0]=1; word with addr[1:0]≠0.

Endianness and lanes:
- Little-endian; byte lane = addr[1:0].
- Store data: byte → {4{d[7:0]}}, ByteEn = 0001<<addr[1:0]. Half → {2{d[15:0]}}, ByteEn = 0011<<addr[1:0]. Word → d, ByteEn = 1111.
- Load: select lane by latched addr[1:0]. Byte/half are sign-extended if MemSigned, else zero-extended.

FSM IDLE / BUSY:
- **IDLE**, access: Stall_OUT=1.
  - At the edge: latch address, size, signed, store data, dest and RegWrite; go to BUSY.
  - Output registers load a bubble (Valid_OUT=0, RegWrite_OUT=0).
- **IDLE**, non-access: Stall_OUT=0.
  - At the edge: Result_OUT←ALUResult_IN, WriteRegister_OUT←WriteRegister_IN.
  - RegWrite_OUT←RegWrite_IN & Valid_IN & !Flush_IN & !misaligned.
  - Valid_OUT←Valid_IN & !Flush_IN.
  - AddrError_OUT←Valid_IN & !Flush_IN & misaligned & (MemRead_IN|MemWrite_IN).
- **BUSY**: DMemReq_OUT=1, driven from latched values.
  - Stall_OUT = !DMemReady_IN.
  - On DMemReady_IN=1: Result_OUT←formatted load data (0 for stores), RegWrite_OUT←latched RegWrite & load, Valid_OUT←1; go to IDLE.
- Flush_IN is ignored in BUSY; an in-flight access always commits.
- DMemReq_OUT is 0 in IDLE. DMemWrite_OUT, DMemAddr_OUT, DMemWriteData_OUT and DMemByteEn_OUT are 0 whenever DMemReq_OUT=0.

## Timing
- Reset (async): state IDLE; every registered output is 0. DMemReq_OUT drops immediately, including mid-BUSY; the in-flight access is abandoned.
- Non-memory or misaligned instruction: latency 1 cycle, no stall.
- Memory access: request is asserted 1 cycle after presentation. Result is valid on the edge after the first DMemReady_IN=1. Total latency = 2 + N cycles for N wait cycles.
- Stall_OUT is high for 1 + N cycles. It falls in the cycle DMemReady_IN is sampled high, so upstream advances on that same edge.
- Back-to-back accesses: at least one IDLE cycle between requests. DMemReq_OUT is low for exactly 1 cycle.
- DMemReady_IN is ignored in IDLE.

## Test plan
- Pass-through: Valid, ALUResult=0x1234_5678, RegWrite, dest=9, no mem → next edge Result_OUT=0x12345678, WriteRegister_OUT=9, RegWrite_OUT=1, Stall_OUT never 1.
- Signed byte load: addr=0x103, size=00, signed, ready after 2 wait cycles, read=0x80FF_FF7F → DMemAddr=0x100, Stall high 3 cycles, Result_OUT=0xFFFF_FF80. Unsigned variant → 0x0000_0080.
- Half store: addr=0x202, size=01, StoreData=0xAAAA_BEEF, ready immediately → DMemWrite=1, ByteEn=1100, WriteData=0xBEEF_BEEF, RegWrite_OUT=0, Valid_OUT=1.
- Misaligned word load: addr=0x101 → no DMemReq, AddrError_OUT=1, RegWrite_OUT=0 on next edge.
- Flush vs in-flight: Flush_IN with a load presented in IDLE → no request, Valid_OUT=0. Flush_IN during BUSY → load still completes, Valid_OUT=1.
- Reset while BUSY (ready held 0): drive RESET=0 mid-wait → DMemReq_OUT falls without a clock, all outputs 0. After release, a new load behaves normally.
